// File: rtl/mem_lsu.sv
// Memory-stage load/store controller: checks alignment and range of each request,
// drives a single data-memory access cycle, then holds the response until it is consumed.
module mem_lsu #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_fault,
    output logic              dm_wr,
    output logic [2:0]        dm_op,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    localparam logic [2:0] OpLw  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLhu = 3'b010;
    localparam logic [2:0] OpSw  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;

    localparam logic [1:0] FaultNone  = 2'b00;
    localparam logic [1:0] FaultAlign = 2'b01;
    localparam logic [1:0] FaultRange = 2'b10;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e              r_state, w_state_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]          r_rsp_fault, w_rsp_fault_nxt;
    logic                r_dm_wr, w_dm_wr_nxt;
    logic [2:0]          r_dm_op, w_dm_op_nxt;
    logic [ADDR_W-1:0]   r_dm_addr, w_dm_addr_nxt;
    logic [31:0]         r_dm_din, w_dm_din_nxt;

    logic w_is_word;
    logic w_is_half;
    logic w_is_store;
    logic w_misaligned;
    logic w_out_of_range;

    always_comb begin
        w_is_word      = (req_op == OpLw) || (req_op == OpSw);
        w_is_half      = (req_op == OpLh) || (req_op == OpLhu) || (req_op == OpSh);
        w_is_store     = (req_op >= OpSw);
        w_misaligned   = (w_is_word && (req_addr[1:0] != 2'b00)) || (w_is_half && req_addr[0]);
        w_out_of_range = |req_addr[31:ADDR_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= FaultNone;
            r_dm_wr     <= 1'b0;
            r_dm_op     <= OpLw;
            r_dm_addr   <= '0;
            r_dm_din    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_fault <= w_rsp_fault_nxt;
            r_dm_wr     <= w_dm_wr_nxt;
            r_dm_op     <= w_dm_op_nxt;
            r_dm_addr   <= w_dm_addr_nxt;
            r_dm_din    <= w_dm_din_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_fault_nxt = r_rsp_fault;
        w_dm_wr_nxt     = r_dm_wr;
        w_dm_op_nxt     = r_dm_op;
        w_dm_addr_nxt   = r_dm_addr;
        w_dm_din_nxt    = r_dm_din;

        case (r_state)
            StIdle: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    if (w_misaligned || w_out_of_range) begin
                        // Faulting requests never reach memory; respond directly.
                        w_rsp_fault_nxt = w_misaligned ? FaultAlign : FaultRange;
                        w_rsp_rdata_nxt = '0;
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = StResp;
                    end else begin
                        w_dm_addr_nxt = req_addr[ADDR_W-1:0];
                        w_dm_op_nxt   = req_op;
                        w_dm_din_nxt  = req_wdata;
                        w_dm_wr_nxt   = w_is_store;
                        w_state_nxt   = StAccess;
                    end
                end
            end
            StAccess: begin
                // Memory writes on any store op, so the op must drop back to a load here.
                w_rsp_rdata_nxt = (r_dm_op >= OpSw) ? 32'h0 : dm_dout;
                w_rsp_fault_nxt = FaultNone;
                w_rsp_valid_nxt = 1'b1;
                w_dm_wr_nxt     = 1'b0;
                w_dm_op_nxt     = OpLw;
                w_state_nxt     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end
            end
            default: begin
                w_state_nxt     = StIdle;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
                w_dm_wr_nxt     = 1'b0;
                w_dm_op_nxt     = OpLw;
            end
        endcase
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign dm_wr     = r_dm_wr;
    assign dm_op     = r_dm_op;
    assign dm_addr   = r_dm_addr;
    assign dm_din    = r_dm_din;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-addressed data-memory model that writes on any store op.
module tb_mem_lsu;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned MEM_BYTES = 1 << ADDR_W;

    localparam logic [2:0] LW  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LHU = 3'b010;
    localparam logic [2:0] LB  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] SW  = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SB  = 3'b111;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_fault;
    logic              dm_wr;
    logic [2:0]        dm_op;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    int checks;
    int errors;

    mem_lsu #(
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .dm_wr     (dm_wr),
        .dm_op     (dm_op),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_dout   (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory model: little-endian, preloaded with byte i = i[7:0].
    logic [7:0] mem [MEM_BYTES];
    logic       mem_clear;
    int         wr_count;
    int         strobe_count;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'(i);
            wr_count     <= 0;
            strobe_count <= 0;
        end else begin
            if (dm_wr) strobe_count <= strobe_count + 1;
            if (dm_op >= SW) begin
                wr_count <= wr_count + 1;
                mem[dm_addr] <= dm_din[7:0];
                if (dm_op == SW || dm_op == SH) mem[ADDR_W'(dm_addr + 1)] <= dm_din[15:8];
                if (dm_op == SW) begin
                    mem[ADDR_W'(dm_addr + 2)] <= dm_din[23:16];
                    mem[ADDR_W'(dm_addr + 3)] <= dm_din[31:24];
                end
            end
        end
    end

    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        b0 = mem[dm_addr];
        b1 = mem[ADDR_W'(dm_addr + 1)];
        b2 = mem[ADDR_W'(dm_addr + 2)];
        b3 = mem[ADDR_W'(dm_addr + 3)];
        dm_dout = 32'h0;
        case (dm_op)
            LW:      dm_dout = {b3, b2, b1, b0};
            LH:      dm_dout = {{16{b1[7]}}, b1, b0};
            LHU:     dm_dout = {16'h0, b1, b0};
            LB:      dm_dout = {{24{b0[7]}}, b0};
            LBU:     dm_dout = {24'h0, b0};
            default: dm_dout = 32'h0;
        endcase
    end

    // Issues one request with rsp_ready=1; lat counts edges from accept until rsp_valid seen.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [1:0] fault, output int lat);
        int waitc;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        fault = rsp_fault;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rstn      = 1'b0;
        mem_clear = 1'b1;
        req_valid = 1'b0;
        req_op    = LW;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_fault !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp got ready=%b valid=%b rdata=%h fault=%b want 1 0 0 00",
                     req_ready, rsp_valid, rsp_rdata, rsp_fault);
        end
        checks++;
        if (dm_wr !== 1'b0 || dm_op !== 3'b000 || dm_addr !== '0 || dm_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_dm got wr=%b op=%b addr=%h din=%h want 0 000 0 0",
                     dm_wr, dm_op, dm_addr, dm_din);
        end
        @(negedge clk);
        mem_clear = 1'b0;
        rstn      = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (dm_op !== 3'b000 || req_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_op got %0d bad cycles want 0", bad);
        end
        checks++;
        if (wr_count !== 0) begin
            errors++;
            $display("FAIL idle_mem got %0d writes want 0", wr_count);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat, w0, s0;
        w0 = wr_count;
        s0 = strobe_count;
        do_req(SW, 32'h10, 32'hDEADBEEF, rd, ft, lat);
        checks++;
        if (lat !== 2 || ft !== 2'b00 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_rsp got lat=%0d fault=%b rdata=%h want 2 00 0", lat, ft, rd);
        end
        checks++;
        if (wr_count - w0 !== 1 || strobe_count - s0 !== 1) begin
            errors++;
            $display("FAIL sw_once got op_cycles=%0d wr_cycles=%0d want 1 1",
                     wr_count - w0, strobe_count - s0);
        end
        checks++;
        if (dm_op !== 3'b000 || dm_wr !== 1'b0 || dm_addr !== 9'h010 || dm_din !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_hold got op=%b wr=%b addr=%h din=%h want 000 0 010 deadbeef",
                     dm_op, dm_wr, dm_addr, dm_din);
        end
        do_req(LW, 32'h10, 32'h0, rd, ft, lat);
        checks++;
        if (lat !== 2 || ft !== 2'b00 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_rsp got lat=%0d fault=%b rdata=%h want 2 00 deadbeef", lat, ft, rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat;
        do_req(SB, 32'h13, 32'h00000080, rd, ft, lat);
        do_req(LB, 32'h13, 32'h0, rd, ft, lat);
        checks++;
        if (rd !== 32'hFFFFFF80 || ft !== 2'b00) begin
            errors++;
            $display("FAIL lb_sext got %h fault=%b want ffffff80 00", rd, ft);
        end
        do_req(LBU, 32'h13, 32'h0, rd, ft, lat);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_zext got %h want 00000080", rd);
        end
        do_req(LW, 32'h10, 32'h0, rd, ft, lat);
        checks++;
        if (rd !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL sb_neighbours got %h want 80adbeef", rd);
        end
        do_req(LB, 32'h1FF, 32'h0, rd, ft, lat);
        checks++;
        if (rd !== 32'hFFFFFFFF || ft !== 2'b00 || lat !== 2) begin
            errors++;
            $display("FAIL lb_top got %h fault=%b lat=%0d want ffffffff 00 2", rd, ft, lat);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat, w0;
        w0 = wr_count;
        do_req(SH, 32'h11, 32'h0000ABCD, rd, ft, lat);
        checks++;
        if (lat !== 1 || ft !== 2'b01 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sh_misalign got lat=%0d fault=%b rdata=%h want 1 01 0", lat, ft, rd);
        end
        do_req(LW, 32'h200, 32'h0, rd, ft, lat);
        checks++;
        if (lat !== 1 || ft !== 2'b10 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_range got lat=%0d fault=%b rdata=%h want 1 10 0", lat, ft, rd);
        end
        do_req(LW, 32'h202, 32'h0, rd, ft, lat);
        checks++;
        if (ft !== 2'b01) begin
            errors++;
            $display("FAIL fault_prio got %b want 01", ft);
        end
        do_req(SW, 32'h8000_0000, 32'hFFFFFFFF, rd, ft, lat);
        checks++;
        if (ft !== 2'b10) begin
            errors++;
            $display("FAIL sw_range got %b want 10", ft);
        end
        checks++;
        if (wr_count !== w0 || dm_op !== 3'b000) begin
            errors++;
            $display("FAIL fault_nowrite got writes=%0d op=%b want %0d 000", wr_count, dm_op, w0);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = LH;
        req_addr  = 32'h20;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got ready=%b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00002120) begin
            errors++;
            $display("FAIL b2b_first got valid=%b rdata=%h want 1 00002120", rsp_valid, rsp_rdata);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00002120 || rsp_fault !== 2'b00 ||
                req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_stall got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handshake got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || dm_op !== LH) begin
            errors++;
            $display("FAIL b2b_second got ready=%b op=%b want 0 001", req_ready, dm_op);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00002120) begin
            errors++;
            $display("FAIL b2b_second_rsp got valid=%b rdata=%h want 1 00002120",
                     rsp_valid, rsp_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_access();
        logic [31:0] rd;
        logic [1:0]  ft;
        int          lat, w0;
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (dm_op !== SW || dm_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_access_pre got op=%b wr=%b want 101 1", dm_op, dm_wr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (dm_op !== 3'b000 || dm_wr !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_clear got op=%b wr=%b ready=%b valid=%b want 000 0 1 0",
                     dm_op, dm_wr, req_ready, rsp_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_count !== w0) begin
            errors++;
            $display("FAIL rst_access_drop got writes=%0d want %0d", wr_count, w0);
        end
        do_req(LW, 32'h30, 32'h0, rd, ft, lat);
        checks++;
        if (rd !== 32'h33323130 || ft !== 2'b00) begin
            errors++;
            $display("FAIL rst_access_mem got %h fault=%b want 33323130 00", rd, ft);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word();
        test_byte();
        test_faults();
        test_back_to_back();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
